// File: rtl/hpdcache_mem_req_write_merger.sv
// rtl/hpdcache_mem_req_write_merger.sv - merges write-request meta and write-data beats into one flit stream
//
// Purpose: sits downstream of the memory write-channel arbiter. Request meta
// (with its beat count) is queued in a small FIFO. Each data beat is bound to
// the meta at the FIFO head and leaves through a registered output stage as a
// flit that carries data, meta, and first/last markers.
//
// Ports:
//   clk_i, rst_ni                           clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_i/req_len_i meta channel (len encodes beats-1)
//   data_valid_i/data_ready_o/data_i        write-data channel
//   data_last_i                             sender's last marker (checked only with the macro)
//   out_valid_o/out_ready_i                 flit handshake
//   out_meta_o/out_data_o/out_first_o/out_last_o  flit fields
//   err_o                                   sticky last-marker mismatch flag
//
// Configuration macro: HPDCACHE_MEM_WRITE_MERGER_LAST_CHK_EN
//   defined   -> data_last_i is compared against the computed last; a mismatch sets err_o
//   undefined -> data_last_i is ignored and err_o is tied low

module hpdcache_mem_req_write_merger #(
    parameter int unsigned META_W     = 64,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [META_W-1:0] req_i,
    input  logic [LEN_W-1:0]  req_len_i,

    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_last_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [META_W-1:0] out_meta_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_first_o,
    output logic              out_last_o,

    output logic              err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Meta FIFO storage. Contents need no reset: validity is tracked by count_q.
    logic [META_W-1:0] meta_q [FIFO_DEPTH];
    logic [LEN_W-1:0]  len_q  [FIFO_DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [META_W-1:0] out_meta_q, out_meta_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;

    logic              push, pop, beat_acc, fifo_nonempty, beat_last;
    logic [META_W-1:0] head_meta;
    logic [LEN_W-1:0]  head_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready is held low during reset so every output reads 0 while rst_ni=0.
    assign req_ready_o   = rst_ni & (count_q < CNT_W'(FIFO_DEPTH));
    assign push          = req_valid_i & req_ready_o;

    // count_q is registered, so a freshly pushed entry is not visible here
    // until the following cycle (no bypass).
    assign fifo_nonempty = (count_q != '0);
    assign head_meta     = meta_q[rptr_q];
    assign head_len      = len_q[rptr_q];

    assign data_ready_o  = fifo_nonempty & (~out_valid_q | out_ready_i);
    assign beat_acc      = data_valid_i & data_ready_o;
    assign beat_last     = (cnt_q == head_len);
    assign pop           = beat_acc & beat_last;

    always_comb begin
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        cnt_d = cnt_q;
        if (beat_acc) begin
            cnt_d = beat_last ? '0 : cnt_q + LEN_W'(1);
        end
    end

    // Output stage: load on accept (possibly in the same cycle the previous
    // flit leaves), otherwise drop valid once the flit is taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_meta_d  = out_meta_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        if (beat_acc) begin
            out_valid_d = 1'b1;
            out_meta_d  = head_meta;
            out_data_d  = data_i;
            out_first_d = (cnt_q == '0);
            out_last_d  = beat_last;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            meta_q[wptr_q] <= req_i;
            len_q[wptr_q]  <= req_len_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_meta_q  <= '0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_meta_q  <= out_meta_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_meta_o  = out_meta_q;
    assign out_data_o  = out_data_q;
    assign out_first_o = out_first_q;
    assign out_last_o  = out_last_q;

`ifdef HPDCACHE_MEM_WRITE_MERGER_LAST_CHK_EN
    // The computed last always drives the flit; the sender's marker is only audited.
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (beat_acc & (data_last_i != beat_last));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_data_last;
    assign unused_data_last = data_last_i;
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpdcache_mem_req_write_merger.sv
// tb/tb_hpdcache_mem_req_write_merger.sv - self-checking bench for hpdcache_mem_req_write_merger
module tb_hpdcache_mem_req_write_merger;

    localparam int META_W = 64;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [META_W-1:0] req_i = '0;
    logic [LEN_W-1:0]  req_len_i = '0;
    logic              data_valid_i = 1'b0;
    logic              data_ready_o;
    logic [DATA_W-1:0] data_i = '0;
    logic              data_last_i = 1'b0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [META_W-1:0] out_meta_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_first_o;
    logic              out_last_o;
    logic              err_o;

    hpdcache_mem_req_write_merger #(
        .META_W(META_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i), .req_len_i(req_len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i), .data_last_i(data_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_meta_o(out_meta_o),
        .out_data_o(out_data_o), .out_first_o(out_first_o), .out_last_o(out_last_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: requests in a queue, beat index within the head request,
    // and the flit the output stage must be presenting.
    typedef struct {
        logic [META_W-1:0] meta;
        logic [LEN_W-1:0]  len;
    } req_t;

    req_t              mq[$];
    int                bi = 0;
    logic              m_valid = 1'b0;
    logic [META_W-1:0] m_meta = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_first = 1'b0;
    logic              m_last = 1'b0;
    logic              m_err = 1'b0;

    // Log of flits taken downstream, used by the hand-computed checks.
    logic [META_W-1:0] lg_meta[$];
    logic [DATA_W-1:0] lg_data[$];
    logic              lg_first[$];
    logic              lg_last[$];
    int                lg_cyc[$];

    task automatic log_clear();
        lg_meta.delete(); lg_data.delete(); lg_first.delete(); lg_last.delete(); lg_cyc.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_ni) begin
            mq.delete();
            bi = 0; m_valid = 0; m_meta = '0; m_data = '0; m_first = 0; m_last = 0; m_err = 0;
        end else begin
            logic exp_rr, exp_dr, acc, push, last;
            exp_rr = (mq.size() < DEPTH);
            exp_dr = (mq.size() > 0) && (!m_valid || out_ready_i);
            chk("m_req_ready", req_ready_o, exp_rr);
            chk("m_data_ready", data_ready_o, exp_dr);
            chk("m_out_valid", out_valid_o, m_valid);
            chk("m_err", err_o, m_err);
            if (m_valid) begin
                chk("m_meta", out_meta_o, m_meta);
                chk("m_data", out_data_o, m_data);
                chk("m_first", out_first_o, m_first);
                chk("m_last", out_last_o, m_last);
            end
            if (out_valid_o && out_ready_i) begin
                lg_meta.push_back(out_meta_o); lg_data.push_back(out_data_o);
                lg_first.push_back(out_first_o); lg_last.push_back(out_last_o);
                lg_cyc.push_back(cyc);
            end
            // Advance to the state after the coming rising edge.
            acc  = data_valid_i && exp_dr;
            push = req_valid_i && exp_rr;
            if (acc) begin
                last    = (bi == int'(mq[0].len));
                m_valid = 1'b1;
                m_meta  = mq[0].meta;
                m_data  = data_i;
                m_first = (bi == 0);
                m_last  = last;
`ifdef HPDCACHE_MEM_WRITE_MERGER_LAST_CHK_EN
                if (data_last_i != last) m_err = 1'b1;
`endif
                if (last) begin
                    void'(mq.pop_front());
                    bi = 0;
                end else begin
                    bi++;
                end
            end else if (out_ready_i) begin
                m_valid = 1'b0;
            end
            if (push) mq.push_back('{meta: req_i, len: req_len_i});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted (bounded); returns the accept cycle.
    task automatic beat(input logic [DATA_W-1:0] d, input logic lst, output int acc_cyc);
        logic got;
        got = 1'b0;
        acc_cyc = -1;
        data_valid_i = 1'b1; data_i = d; data_last_i = lst;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = data_ready_o;
            if (got) acc_cyc = cyc;
            step();
        end
        if (!got) chk("beat_timeout", 0, 1);
        data_valid_i = 1'b0; data_last_i = 1'b0;
    endtask

    task automatic push_req(input logic [META_W-1:0] m, input logic [LEN_W-1:0] l);
        req_valid_i = 1'b1; req_i = m; req_len_i = l;
        step();
        req_valid_i = 1'b0;
    endtask

    initial begin
        int a0, tmp, nlast;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_data_ready", data_ready_o, 0);
        chk("rst_meta", out_meta_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_first", out_first_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_err", err_o, 0);
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready_o, 1);
        chk("post_rst_data_ready", data_ready_o, 0);
        step();

        // One len=3 request, four beats at full throughput
        log_clear();
        push_req(64'hA5, 8'd3);
        beat(128'h100, 1'b0, a0);
        for (int k = 1; k < 4; k++) beat(128'h100 + 128'(k), k == 3, tmp);
        repeat (3) step();
        chk("t2_nflits", lg_meta.size(), 4);
        for (int k = 0; k < 4 && k < lg_meta.size(); k++) begin
            chk("t2_meta", lg_meta[k], 64'hA5);
            chk("t2_data", lg_data[k], 128'h100 + 128'(k));
            chk("t2_first", lg_first[k], k == 0);
            chk("t2_last", lg_last[k], k == 3);
            chk("t2_cycle", lg_cyc[k], a0 + 1 + k);
        end

        // Data before meta
        data_valid_i = 1'b1; data_i = 128'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t3_dr_early", data_ready_o, 0); step();
        end
        req_valid_i = 1'b1; req_i = 64'h11; req_len_i = 8'd0;
        @(negedge clk); chk("t3_dr_push_cycle", data_ready_o, 0); step();
        req_valid_i = 1'b0;
        @(negedge clk); chk("t3_dr_after", data_ready_o, 1); step();
        data_valid_i = 1'b0;
        repeat (2) step();

        // Backpressure
        out_ready_i = 1'b0;
        push_req(64'h22, 8'd1);
        beat(128'h400, 1'b0, tmp);
        data_valid_i = 1'b1; data_i = 128'h401; data_last_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", out_valid_o, 1);
            chk("t4_hold_data", out_data_o, 128'h400);
            chk("t4_hold_meta", out_meta_o, 64'h22);
            chk("t4_hold_first", out_first_o, 1);
            chk("t4_hold_dr", data_ready_o, 0);
            step();
        end
        out_ready_i = 1'b1;
        @(negedge clk); chk("t4_dr_release", data_ready_o, 1); step();
        data_valid_i = 1'b0; data_last_i = 1'b0;
        @(negedge clk);
        chk("t4_beat1_data", out_data_o, 128'h401);
        chk("t4_beat1_last", out_last_o, 1);
        repeat (2) step();

        // FIFO full with three single-beat requests
        log_clear();
        req_valid_i = 1'b1; req_i = 64'h31; req_len_i = 8'd0;
        @(negedge clk); chk("t5_rr0", req_ready_o, 1); step();
        req_i = 64'h32;
        @(negedge clk); chk("t5_rr1", req_ready_o, 1); step();
        req_i = 64'h33;
        data_valid_i = 1'b1; data_i = 128'h501;
        @(negedge clk); chk("t5_rr_full", req_ready_o, 0); step();
        data_i = 128'h502;
        @(negedge clk); chk("t5_rr_after_pop", req_ready_o, 1); step();
        req_valid_i = 1'b0;
        data_i = 128'h503;
        @(negedge clk); chk("t5_dr_third", data_ready_o, 1); step();
        data_valid_i = 1'b0;
        repeat (3) step();
        chk("t5_nflits", lg_meta.size(), 3);
        for (int k = 0; k < 3 && k < lg_meta.size(); k++) begin
            chk("t5_meta", lg_meta[k], 64'h31 + 64'(k));
            chk("t5_data", lg_data[k], 128'h501 + 128'(k));
            chk("t5_firstlast", {lg_first[k], lg_last[k]}, 2'b11);
        end

        // Wrong sender last marker
        log_clear();
        push_req(64'h44, 8'd2);
        beat(128'h600, 1'b0, tmp);
        beat(128'h601, 1'b1, tmp);
`ifdef HPDCACHE_MEM_WRITE_MERGER_LAST_CHK_EN
        chk("t6_err_rise", err_o, 1);
`else
        chk("t6_err_tied", err_o, 0);
`endif
        beat(128'h602, 1'b0, tmp);
        repeat (3) step();
`ifdef HPDCACHE_MEM_WRITE_MERGER_LAST_CHK_EN
        chk("t6_err_sticky", err_o, 1);
`else
        chk("t6_err_still_tied", err_o, 0);
`endif
        chk("t6_nflits", lg_meta.size(), 3);
        if (lg_meta.size() == 3) chk("t6_last_pattern", {lg_last[0], lg_last[1], lg_last[2]}, 3'b001);

        // Maximum length request
        log_clear();
        push_req(64'h77, 8'd255);
        for (int k = 0; k < 256; k++) beat(128'(k), k == 255, tmp);
        repeat (3) step();
        chk("t7_nflits", lg_meta.size(), 256);
        nlast = 0;
        foreach (lg_last[k]) if (lg_last[k]) nlast++;
        chk("t7_nlast", nlast, 1);
        if (lg_meta.size() == 256) begin
            chk("t7_last_pos", lg_last[255], 1);
            chk("t7_first_pos", lg_first[0], 1);
            chk("t7_mid_first", lg_first[128], 0);
        end

        // Reset in the middle of a request
        push_req(64'h88, 8'd3);
        beat(128'h800, 1'b0, tmp);
        beat(128'h801, 1'b0, tmp);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("t8_rst_valid", out_valid_o, 0);
        chk("t8_rst_dr", data_ready_o, 0);
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("t8_rr", req_ready_o, 1);
        chk("t8_dr_empty", data_ready_o, 0);
        chk("t8_err_clear", err_o, 0);
        step();
        push_req(64'h99, 8'd0);
        beat(128'h900, 1'b1, tmp);
        @(negedge clk);
        chk("t8_fresh_first", out_first_o, 1);
        chk("t8_fresh_meta", out_meta_o, 64'h99);
        step();
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
